alu_wb_stage: RTL



---
 rtl/alu_pkg.sv | 17 +
 rtl/wb_fifo.sv | 51 +++++
 rtl/alu_wb_stage.sv | 89 ++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU/writeback definitions.
// Widths, writeback entry layout and flag bit positions.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int DEST_W = 3;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DEST_W-1:0] dest;
        logic              wr_en;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry synchronous FIFO of writeback entries with occupancy count.
// Ports: clk, rst, push/wr_data in, pop in, rd_data (head) out, count out.
module wb_fifo
    import alu_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = wb_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  entry_t                   wr_data,
    input  logic                     pop,
    output entry_t                   rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/alu_wb_stage.sv
// ALU result/writeback stage: queues results for register writeback and
// owns carry/zero flags. Ports: in_* (ALU side), out_* (writeback), flags.
module alu_wb_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int DEST_W = alu_pkg::DEST_W,
    parameter int DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_result,
    input  logic                   in_carry,
    input  logic                   in_compare,
    input  logic [DEST_W-1:0]      in_dest,
    input  logic                   in_wr_en,
    input  logic                   in_flags_we,
    input  logic                   flags_clear,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_result,
    output logic [DEST_W-1:0]      out_dest,
    output logic                   out_wr_en,
    output logic                   carry_flag,
    output logic                   zero_flag,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DEST_W-1:0] dest;
        logic              wr_en;
    } entry_t;

    entry_t     wr_data;
    entry_t     head;
    logic       push;
    logic       pop;
    logic [1:0] flags;

    // Ready depends only on occupancy: a full FIFO never
    // accepts, even when the head is popped this cycle.
    assign in_ready  = (count < FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign wr_data.result = in_result;
    assign wr_data.dest   = in_dest;
    assign wr_data.wr_en  = in_wr_en;

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (wr_data),
        .pop     (pop),
        .rd_data (head),
        .count   (count)
    );

    assign out_result = head.result;
    assign out_dest   = head.dest;
    assign out_wr_en  = head.wr_en;

    // Clear beats an update from the same cycle's push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= '0;
        end else if (flags_clear) begin
            flags <= '0;
        end else if (push && in_flags_we) begin
            flags[FLAG_C] <= in_carry;
            flags[FLAG_Z] <= in_compare;
        end
    end

    assign carry_flag = flags[FLAG_C];
    assign zero_flag  = flags[FLAG_Z];

endmodule
